// File: rtl/contador_arbiter_if.sv
// Requester, engine and response signals of the contador_arbiter bit-count scheduler.
// master = arbiter side, slave = requester agents / engine side.
interface contador_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int CW = $clog2(DW + 1);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic               cnt_valid;
    logic [DW-1:0]      cnt_data;
    logic               cnt_ready;
    logic               cnt_done;
    logic [CW-1:0]      cnt_result;

    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic [CW-1:0]      rsp_count;
    logic               rsp_err;
    logic               busy;

    modport master (
        input  req_valid, req_data, cnt_ready, cnt_done, cnt_result,
        output req_ready, cnt_valid, cnt_data, rsp_valid, rsp_id, rsp_count, rsp_err, busy
    );

    modport slave (
        output req_valid, req_data, cnt_ready, cnt_done, cnt_result,
        input  req_ready, cnt_valid, cnt_data, rsp_valid, rsp_id, rsp_count, rsp_err, busy
    );
endinterface

// File: rtl/contador_arbiter.sv
// Round-robin scheduler sharing one bit-counting engine among NREQ requesters.
// Optional watchdog on the engine handshake: define CONTADOR_ARB_TIMEOUT_EN.
module contador_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    contador_arbiter_if.master bus
);
    localparam int          CW = $clog2(DW + 1);
    localparam int          IW = $clog2(NREQ);
    localparam int unsigned NR = NREQ;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [IW-1:0]   last_grant;

    logic [NREQ-1:0] req_ready_q;
    logic            cnt_valid_q;
    logic [DW-1:0]   cnt_data_q;
    logic            rsp_valid_q;
    logic [IW-1:0]   rsp_id_q;
    logic [CW-1:0]   rsp_count_q;
    logic            busy_q;

    logic            found;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_onehot;

`ifdef CONTADOR_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wd_cnt;
    logic            rsp_err_q;
`endif

    // First pending requester searching upward from last_grant+1, wrapping at NREQ.
    always_comb begin
        found      = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            if (!found && bus.req_valid[IW'((32'(last_grant) + k) % NR)]) begin
                found   = 1'b1;
                gnt_idx = IW'((32'(last_grant) + k) % NR);
            end
        end
        gnt_onehot[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            last_grant  <= IW'(NREQ - 1);
            req_ready_q <= '0;
            cnt_valid_q <= 1'b0;
            cnt_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            busy_q      <= 1'b0;
`ifdef CONTADOR_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready_q <= '0;
                    rsp_valid_q <= 1'b0;
                    if (found) begin
                        req_ready_q <= gnt_onehot;
                        cnt_valid_q <= 1'b1;
                        cnt_data_q  <= bus.req_data[gnt_idx*DW +: DW];
                        rsp_id_q    <= gnt_idx;
                        busy_q      <= 1'b1;
                        state       <= S_ISSUE;
`ifdef CONTADOR_ARB_TIMEOUT_EN
                        wd_cnt      <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    req_ready_q <= '0;
                    if (bus.cnt_ready) begin
                        cnt_valid_q <= 1'b0;
                        state       <= S_WAIT;
`ifdef CONTADOR_ARB_TIMEOUT_EN
                        wd_cnt      <= '0;
                    end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        cnt_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_count_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wd_cnt      <= wd_cnt + TW'(1);
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.cnt_done) begin
                        rsp_count_q <= bus.cnt_result;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
`ifdef CONTADOR_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_count_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wd_cnt      <= wd_cnt + TW'(1);
`endif
                    end
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    last_grant  <= rsp_id_q;
                    busy_q      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.cnt_valid = cnt_valid_q;
    assign bus.cnt_data  = cnt_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.busy      = busy_q;
`ifdef CONTADOR_ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_contador_arbiter.sv
// Directed bench for contador_arbiter: transaction table plus backpressure, reset and watchdog sequences.
module tb_contador_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] result;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[12];
    vec_t v;
    int   n;

    contador_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    contador_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_req_ready", idx, 32'(bus.req_ready), 0);
        chk("rst_cnt_valid", idx, 32'(bus.cnt_valid), 0);
        chk("rst_cnt_data",  idx, 32'(bus.cnt_data),  0);
        chk("rst_rsp_valid", idx, 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id",    idx, 32'(bus.rsp_id),    0);
        chk("rst_rsp_count", idx, 32'(bus.rsp_count), 0);
        chk("rst_rsp_err",   idx, 32'(bus.rsp_err),   0);
        chk("rst_busy",      idx, 32'(bus.busy),      0);
    endtask

    // One transaction with an engine that is ready at once and done one cycle later.
    task automatic run_txn(input int idx, input vec_t t);
        bus.req_valid  = t.mask;
        bus.cnt_ready  = 1'b1;
        bus.cnt_done   = 1'b0;
        tick();
        chk("req_ready",  idx, 32'(bus.req_ready), 32'(t.exp_gnt));
        chk("cnt_valid1", idx, 32'(bus.cnt_valid), 1);
        chk("cnt_data",   idx, 32'(bus.cnt_data),  32'(t.exp_data));
        chk("busy1",      idx, 32'(bus.busy),      1);
        bus.req_valid  = '0;
        tick();
        chk("req_ready0", idx, 32'(bus.req_ready), 0);
        chk("cnt_valid0", idx, 32'(bus.cnt_valid), 0);
        chk("rsp_early",  idx, 32'(bus.rsp_valid), 0);
        bus.cnt_done   = 1'b1;
        bus.cnt_result = t.result;
        tick();
        chk("rsp_valid",  idx, 32'(bus.rsp_valid), 1);
        chk("rsp_id",     idx, 32'(bus.rsp_id),    32'(t.exp_id));
        chk("rsp_count",  idx, 32'(bus.rsp_count), 32'(t.result));
        chk("rsp_err",    idx, 32'(bus.rsp_err),   0);
        bus.cnt_done   = 1'b0;
        tick();
        chk("rsp_pulse",  idx, 32'(bus.rsp_valid), 0);
        chk("busy0",      idx, 32'(bus.busy),      0);
    endtask

    initial begin
        // Words: req0=B5 (5 ones), req1=81 (2), req2=3C (4), req3=0F (4).
        vecs[0]  = '{4'b0001, 4'd5, 4'b0001, 2'd0, 8'hB5};
        vecs[1]  = '{4'b1111, 4'd2, 4'b0010, 2'd1, 8'h81};
        vecs[2]  = '{4'b1111, 4'd4, 4'b0100, 2'd2, 8'h3C};
        vecs[3]  = '{4'b1111, 4'd4, 4'b1000, 2'd3, 8'h0F};
        vecs[4]  = '{4'b1111, 4'd5, 4'b0001, 2'd0, 8'hB5};
        vecs[5]  = '{4'b1010, 4'd2, 4'b0010, 2'd1, 8'h81};
        vecs[6]  = '{4'b1010, 4'd4, 4'b1000, 2'd3, 8'h0F};
        vecs[7]  = '{4'b1010, 4'd2, 4'b0010, 2'd1, 8'h81};
        vecs[8]  = '{4'b0100, 4'd4, 4'b0100, 2'd2, 8'h3C};
        vecs[9]  = '{4'b0101, 4'd5, 4'b0001, 2'd0, 8'hB5};
        vecs[10] = '{4'b1000, 4'd4, 4'b1000, 2'd3, 8'h0F};
        vecs[11] = '{4'b0001, 4'd5, 4'b0001, 2'd0, 8'hB5};

        bus.req_valid  = '0;
        bus.req_data   = 32'h0F3C_81B5;
        bus.cnt_ready  = 1'b0;
        bus.cnt_done   = 1'b0;
        bus.cnt_result = '0;

        #1 reset = 1'b0;
        #2 chk_all_zero(0);
        #9 reset = 1'b1;
        tick();
        chk_all_zero(1);

        for (int i = 0; i < 12; i++) run_txn(i, vecs[i]);

        // Idle with nothing pending: no grant, not busy.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready", i, 32'(bus.req_ready), 0);
            chk("idle_busy",  i, 32'(bus.busy),      0);
        end

        // Backpressure: engine not ready for 6 cycles, stray done in ISSUE ignored.
        bus.req_valid = 4'b0001;
        bus.cnt_ready = 1'b0;
        tick();
        chk("bp_grant", 0, 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            bus.cnt_done   = (i == 3);
            bus.cnt_result = 4'd7;
            tick();
            chk("bp_cnt_valid", i, 32'(bus.cnt_valid), 1);
            chk("bp_cnt_data",  i, 32'(bus.cnt_data),  32'hB5);
            chk("bp_rsp_valid", i, 32'(bus.rsp_valid), 0);
        end
        bus.cnt_done  = 1'b0;
        bus.cnt_ready = 1'b1;
        tick();
        chk("bp_released", 0, 32'(bus.cnt_valid), 0);
        tick();
        chk("bp_wait", 0, 32'(bus.rsp_valid), 0);
        bus.cnt_done   = 1'b1;
        bus.cnt_result = 4'd3;
        tick();
        chk("bp_rsp_valid_end", 0, 32'(bus.rsp_valid), 1);
        chk("bp_rsp_count",     0, 32'(bus.rsp_count), 3);
        bus.cnt_done = 1'b0;
        tick();

        // Reset while waiting on the engine: outputs clear without a clock edge.
        bus.req_valid = 4'b0100;
        bus.cnt_ready = 1'b1;
        tick();
        chk("rw_grant", 0, 32'(bus.req_ready), 32'b0100);
        bus.req_valid = '0;
        tick();
        chk("rw_busy", 0, 32'(bus.busy), 1);
        #2 reset = 1'b0;
        #1 chk_all_zero(2);
        #2 reset = 1'b1;
        bus.cnt_done   = 1'b1;
        bus.cnt_result = 4'd9;
        tick();
        bus.cnt_done = 1'b0;
        chk("rw_stray", 0, 32'(bus.rsp_valid), 0);
        tick();
        chk("rw_stray", 1, 32'(bus.rsp_valid), 0);
        chk("rw_idle",  0, 32'(bus.busy),      0);
        v = '{4'b1111, 4'd5, 4'b0001, 2'd0, 8'hB5};
        run_txn(20, v);

`ifdef CONTADOR_ARB_TIMEOUT_EN
        // Engine never completes: watchdog answers with an error response.
        bus.req_valid = 4'b0010;
        bus.cnt_ready = 1'b1;
        tick();
        chk("to_grant", 0, 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        tick();
        chk("to_wait", 0, 32'(bus.cnt_valid), 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.rsp_valid !== 1'b1 && n < 40);
        chk("to_latency", 0, 32'(n), 15);
        chk("to_rsp_err", 0, 32'(bus.rsp_err),   1);
        chk("to_rsp_cnt", 0, 32'(bus.rsp_count), 0);
        chk("to_rsp_id",  0, 32'(bus.rsp_id),    1);
        tick();
        v = '{4'b1111, 4'd4, 4'b0100, 2'd2, 8'h3C};
        run_txn(21, v);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/contador_arbiter.md
# contador_arbiter

Round-robin scheduler that shares one bit-counting engine among `NREQ` requesters. Each requester presents a data word; the arbiter grants one at a time, sequences the engine through issue/wait, and returns the engine's count tagged with the requester index. It sits between the requester agents and the single counter instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: data word width.
- `CW`, `$clog2(DW+1)`: count width, derived; do not override.
- `TIMEOUT`, 15: watchdog limit in cycles. Used only with `CONTADOR_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request; held until its `req_ready` bit pulses.
- `req_data`  in  NREQ*DW  requester i word at bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-cycle one-hot accept pulse.
- `cnt_valid`  out  1  issue request to the engine.
- `cnt_data`  out  DW  word for the engine.
- `cnt_ready`  in  1  engine accepts the issue.
- `cnt_done`  in  1  engine result valid, one-cycle pulse.
- `cnt_result`  in  CW  engine count.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_id`  out  `$clog2(NREQ)`  served requester index.
- `rsp_count`  out  CW  returned count.
- `rsp_err`  out  1  response aborted by the watchdog.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if any `req_valid` is set, select the first set bit searching upward from `last_grant+1`, mod NREQ. On that edge:
  - latch `cnt_data` and `rsp_id`;
  - set `req_ready[g]` for exactly one cycle;
  - go to ISSUE.
- ISSUE: `cnt_valid`=1. Hold `cnt_data` stable. On an edge with `cnt_ready`=1, clear `cnt_valid` and go to WAIT. `cnt_done` is ignored in ISSUE.
- WAIT: on an edge with `cnt_done`=1, capture `cnt_result` into `rsp_count` and go to RESP.
- RESP: `rsp_valid`=1 for one cycle. Set `last_grant`=`rsp_id`. Go to IDLE.
- Requests arriving while `busy`=1 stay pending; no queueing beyond the `req_valid` levels.
- If all requesters are valid, service rotates 0,1,2,3,0…; no requester waits more than NREQ-1 services.
- `req_valid` dropped before it is granted is simply not served; no error.
- Reset (asynchronous assert, any state):
  - state returns to IDLE;
  - `last_grant`=NREQ-1, so requester 0 has first priority;
  - all outputs go to 0, including `cnt_data`, `rsp_id`, `rsp_count`, `rsp_err`, `busy`, `req_ready`.
  - An in-flight engine transaction is abandoned; a later stray `cnt_done` in IDLE is ignored.

## Timing
- Edge E0 samples `req_valid`. `req_ready` and `cnt_valid` are high in the cycle after E0.
- With `cnt_ready`=1 at E1 and `cnt_done`=1 at E2, `rsp_valid` is high in the cycle after E2. Minimum request-to-response latency is 3 cycles.
- Minimum back-to-back service period is 4 cycles: IDLE, ISSUE, WAIT, RESP.
- `req_ready` is never high for two consecutive cycles and never has more than one bit set.

## Configuration
- `CONTADOR_ARB_TIMEOUT_EN` defined:
  - a counter runs in ISSUE and WAIT, clearing on entry to each state;
  - when it reaches `TIMEOUT` without the awaited `cnt_ready`/`cnt_done`, the FSM goes to RESP with `rsp_err`=1 and `rsp_count`=0, and drops `cnt_valid`;
  - the round-robin pointer advances normally.
- Macro undefined: no watchdog; ISSUE and WAIT wait indefinitely; `rsp_err` is tied to 0.

## Test plan
- Reset and single request: `reset` low, then high; `req_valid`=4'b0001, `req_data[7:0]`=8'hB5; engine ready immediately, done next cycle with 5 → `req_ready`=4'b0001 for one cycle; `cnt_data`=8'hB5; `rsp_valid` with `rsp_id`=0, `rsp_count`=5, exactly 3 cycles after the sampling edge.
- All four requesters valid continuously → grants in order 0,1,2,3,0, one every 4 cycles; `rsp_id` sequence matches.
- Backpressure: `cnt_ready` low for 6 cycles in ISSUE → `cnt_valid` and `cnt_data` stable for all 6 cycles; a `cnt_done` pulse during ISSUE is ignored; response follows a later done.
- Fairness: requesters 1 and 3 valid, `last_grant`=1 → 3 is served, then 1.
- Reset mid-WAIT: `reset` low while in WAIT → all outputs 0 asynchronously; a stray `cnt_done` afterwards produces no `rsp_valid`; the next request goes to requester 0 first.
- With `CONTADOR_ARB_TIMEOUT_EN`, `TIMEOUT`=15: engine never sends `cnt_done` → `rsp_valid` with `rsp_err`=1, `rsp_count`=0 15 cycles after WAIT entry; the next grant proceeds normally.
